// File: rtl/baud_tick_gen.sv
// Fractional baud-rate strobe generator: independent RX (oversample, phase, bit-centre)
// and TX (bit) divider chains sharing one runtime-writable int.frac divisor.
module baud_tick_gen #(
  parameter int CLOCK_RATE = 100000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_INT_W  = 16,
  parameter int DIV_FRAC_W = 4,
  parameter int OS_W       = $clog2(OVERSAMPLE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  div_wr,
  input  logic [DIV_INT_W-1:0]  div_int,
  input  logic [DIV_FRAC_W-1:0] div_frac,
  input  logic                  rx_resync,
  output logic                  rx_tick,
  output logic [OS_W-1:0]       rx_phase,
  output logic                  rx_mid,
  output logic                  tx_tick,
  output logic                  div_pending
);

  // Period counter is one bit wider than the integer part so int + carry never overflows.
  localparam int CW = DIV_INT_W + 1;

  localparam logic [63:0] TICK_HZ = 64'(BAUD_RATE) * 64'(OVERSAMPLE);
  localparam logic [63:0] D0 =
    (64'(CLOCK_RATE) * (64'd1 << DIV_FRAC_W) + TICK_HZ / 64'd2) / TICK_HZ;

  localparam logic [DIV_INT_W-1:0]  MIN_INT    = DIV_INT_W'(2);
  localparam logic [DIV_INT_W-1:0]  D0_INT_RAW = DIV_INT_W'(D0 >> DIV_FRAC_W);
  localparam logic [DIV_INT_W-1:0]  D0_INT     = (D0_INT_RAW < MIN_INT) ? MIN_INT : D0_INT_RAW;
  localparam logic [DIV_FRAC_W-1:0] D0_FRAC    = DIV_FRAC_W'(D0);

  localparam logic [OS_W-1:0] MID_PH  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] LAST_PH = OS_W'(OVERSAMPLE - 1);

  // Shared shadow divisor, loaded by div_wr and adopted by each chain at its next period start.
  logic [DIV_INT_W-1:0]  sh_int_q, sh_int_d;
  logic [DIV_FRAC_W-1:0] sh_frac_q, sh_frac_d;

  // Per-chain state, index 0 = RX, index 1 = TX.
  logic [CW-1:0]         cnt_q   [2];
  logic [CW-1:0]         cnt_d   [2];
  logic [DIV_FRAC_W-1:0] acc_q   [2];
  logic [DIV_FRAC_W-1:0] acc_d   [2];
  logic [OS_W-1:0]       phase_q [2];
  logic [OS_W-1:0]       phase_d [2];
  logic [DIV_INT_W-1:0]  int_q   [2];
  logic [DIV_INT_W-1:0]  int_d   [2];
  logic [DIV_FRAC_W-1:0] frac_q  [2];
  logic [DIV_FRAC_W-1:0] frac_d  [2];
  logic                  pend_q  [2];
  logic                  pend_d  [2];
  logic                  tick_q  [2];
  logic                  tick_d  [2];
  logic                  mid_q, mid_d;

  always_comb begin
    sh_int_d  = sh_int_q;
    sh_frac_d = sh_frac_q;
    if (div_wr) begin
      sh_int_d  = (div_int < MIN_INT) ? MIN_INT : div_int;
      sh_frac_d = div_frac;
    end

    mid_d = 1'b0;

    for (int i = 0; i < 2; i++) begin : g_chain
      logic                  restart;
      logic                  is_end;
      logic                  is_start;
      logic [DIV_INT_W-1:0]  sel_int;
      logic [DIV_FRAC_W-1:0] sel_frac;
      logic [DIV_FRAC_W-1:0] acc_base;
      logic [DIV_FRAC_W:0]   sum;

      cnt_d[i]   = cnt_q[i];
      acc_d[i]   = acc_q[i];
      phase_d[i] = phase_q[i];
      int_d[i]   = int_q[i];
      frac_d[i]  = frac_q[i];
      pend_d[i]  = pend_q[i];
      tick_d[i]  = 1'b0;

      restart  = (i == 0) ? rx_resync : 1'b0;
      sel_int  = pend_q[i] ? sh_int_q : int_q[i];
      sel_frac = pend_q[i] ? sh_frac_q : frac_q[i];

      // cnt == 0 marks a cleared chain whose next edge starts a period without a strobe;
      // cnt == 1 is the last clock of a running period, which also starts the next one.
      is_end   = en && !restart && (cnt_q[i] == CW'(1));
      is_start = en && (restart || (cnt_q[i] == '0) || is_end);
      acc_base = restart ? '0 : acc_q[i];
      sum      = {1'b0, acc_base} + {1'b0, sel_frac};

      if (!en) begin
        cnt_d[i]   = '0;
        acc_d[i]   = '0;
        phase_d[i] = '0;
      end else if (is_start) begin
        cnt_d[i] = {1'b0, sel_int} + CW'(sum[DIV_FRAC_W]);
        acc_d[i] = sum[DIV_FRAC_W-1:0];
        if (restart) begin
          phase_d[i] = '0;
        end else if (is_end) begin
          phase_d[i] = phase_q[i] + OS_W'(1);
        end
      end else begin
        cnt_d[i] = cnt_q[i] - CW'(1);
      end

      if (i == 0) begin
        tick_d[i] = is_end;
        mid_d     = is_end && (phase_q[i] == MID_PH);
      end else begin
        tick_d[i] = is_end && (phase_q[i] == LAST_PH);
      end

      // A held chain adopts immediately; a running one only where a period begins.
      if (pend_q[i] && (!en || is_start)) begin
        int_d[i]  = sh_int_q;
        frac_d[i] = sh_frac_q;
        pend_d[i] = 1'b0;
      end
      if (div_wr) begin
        pend_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_int_q  <= D0_INT;
      sh_frac_q <= D0_FRAC;
      mid_q     <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i]   <= '0;
        acc_q[i]   <= '0;
        phase_q[i] <= '0;
        int_q[i]   <= D0_INT;
        frac_q[i]  <= D0_FRAC;
        pend_q[i]  <= 1'b0;
        tick_q[i]  <= 1'b0;
      end
    end else begin
      sh_int_q  <= sh_int_d;
      sh_frac_q <= sh_frac_d;
      mid_q     <= mid_d;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i]   <= cnt_d[i];
        acc_q[i]   <= acc_d[i];
        phase_q[i] <= phase_d[i];
        int_q[i]   <= int_d[i];
        frac_q[i]  <= frac_d[i];
        pend_q[i]  <= pend_d[i];
        tick_q[i]  <= tick_d[i];
      end
    end
  end

  assign rx_tick     = tick_q[0];
  assign tx_tick     = tick_q[1];
  assign rx_mid      = mid_q;
  assign rx_phase    = phase_q[0];
  assign div_pending = pend_q[0] | pend_q[1];

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen: strobe timing table plus hand-written multi-cycle
// sequences (divisor change, resync, en drop, asynchronous reset).
module tb_baud_tick_gen;

  localparam int OS_W = 4;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        div_wr;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        rx_resync;
  logic        rx_tick;
  logic [OS_W-1:0] rx_phase;
  logic        rx_mid;
  logic        tx_tick;
  logic        div_pending;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  // Edge numbers (cyc) of every strobe seen, plus the phase shown during each rx_tick.
  int rx_q[$];
  int tx_q[$];
  int mid_q[$];
  logic [OS_W-1:0] ph_q[$];
  logic [OS_W-1:0] exp_q[$];

  typedef struct {
    logic [15:0] di;
    logic [3:0]  df;
    int          p0;
    int          p1;
    int          ptx;
  } vec_t;
  vec_t vecs[5];

  baud_tick_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .div_wr      (div_wr),
    .div_int     (div_int),
    .div_frac    (div_frac),
    .rx_resync   (rx_resync),
    .rx_tick     (rx_tick),
    .rx_phase    (rx_phase),
    .rx_mid      (rx_mid),
    .tx_tick     (tx_tick),
    .div_pending (div_pending)
  );

  // ---------------- clock / cycle counter ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_tick) begin
      rx_q.push_back(cyc);
      ph_q.push_back(rx_phase);
    end
    if (tx_tick) tx_q.push_back(cyc);
    if (rx_mid) mid_q.push_back(cyc);
  end

  // ---------------- driver / checker tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int qsize(input int which);
    case (which)
      0:       return rx_q.size();
      1:       return tx_q.size();
      default: return mid_q.size();
    endcase
  endfunction

  function automatic int at(input int which, input int i);
    if (i < 0 || i >= qsize(which)) return -1;
    case (which)
      0:       return rx_q[i];
      1:       return tx_q[i];
      default: return mid_q[i];
    endcase
  endfunction

  task automatic wait_q(input int which, input int n, input string name);
    int b;
    b = 0;
    while (qsize(which) < n && b < 20000) begin
      step();
      b++;
    end
    if (qsize(which) < n) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: timeout with %0d strobes, required %0d", name, qsize(which), n);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int s, r, r2, nr, nt, nm, fall, b;

    vecs[0] = '{di: 16'd10, df: 4'd0,  p0: 10, p1: 10, ptx: 160};
    vecs[1] = '{di: 16'd0,  df: 4'd0,  p0: 2,  p1: 2,  ptx: 32};
    vecs[2] = '{di: 16'd1,  df: 4'd15, p0: 2,  p1: 3,  ptx: 47};
    vecs[3] = '{di: 16'd4,  df: 4'd8,  p0: 4,  p1: 5,  ptx: 72};
    vecs[4] = '{di: 16'd7,  df: 4'd4,  p0: 7,  p1: 7,  ptx: 116};

    rst_n = 1'b1; en = 1'b0; div_wr = 1'b0; div_int = '0; div_frac = '0; rx_resync = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("reset_rx_tick", rx_tick, 0);
    check("reset_rx_phase", rx_phase, 0);
    check("reset_rx_mid", rx_mid, 0);
    check("reset_tx_tick", tx_tick, 0);
    check("reset_div_pending", div_pending, 0);
    repeat (3) step();
    check("reset_hold_pending", div_pending, 0);

    // Default divisor 651 + 1/16
    rst_n = 1'b1;
    en = 1'b1;
    s = cyc + 1;
    wait_q(0, 16, "default_rx_ticks");
    for (int k = 0; k < 16; k++) begin
      check($sformatf("default_period%0d", k),
            at(0, k) - ((k == 0) ? s : at(0, k - 1)), (k == 15) ? 652 : 651);
      exp_q.push_back(OS_W'((k + 1) % 16));
    end
    while (exp_q.size() > 0 && ph_q.size() > 0) check("default_rx_phase", ph_q.pop_front(), exp_q.pop_front());
    check("default_phase_count", exp_q.size(), 0);
    wait_q(2, 1, "default_mid");
    check("default_mid_time", at(2, 0) - s, 8 * 651);
    check("default_mid_count", mid_q.size(), 1);
    wait_q(1, 1, "default_tx");
    check("default_tx_first", at(1, 0) - s, 10417);

    // Divisor write mid-period: both chains adopt at the next period boundary (tick 17)
    repeat (100) step();
    nr = rx_q.size();
    nt = tx_q.size();
    div_int = 16'd10; div_frac = 4'd0; div_wr = 1'b1;
    step();
    div_wr = 1'b0;
    check("wr_pending_set", div_pending, 1);
    b = 0;
    while (div_pending && b < 2000) begin step(); b++; end
    fall = cyc;
    check("wr_pending_clear", div_pending, 0);
    check("wr_pending_fall_time", fall - s, 10417 + 651);
    wait_q(0, nr + 3, "wr_rx_ticks");
    check("wr_adopt_tick", at(0, nr) - s, 10417 + 651);
    check("wr_rx_spacing1", at(0, nr + 1) - at(0, nr), 10);
    check("wr_rx_spacing2", at(0, nr + 2) - at(0, nr + 1), 10);
    wait_q(1, nt + 2, "wr_tx_ticks");
    check("wr_tx_first", at(1, nt) - s, 10417 + 651 + 150);
    check("wr_tx_spacing", at(1, nt + 1) - at(1, nt), 160);

    // rx_resync mid-period
    nr = rx_q.size();
    wait_q(0, nr + 1, "resync_align");
    repeat (4) step();
    nr = rx_q.size();
    nt = tx_q.size();
    nm = mid_q.size();
    rx_resync = 1'b1;
    r = cyc + 1;
    step();
    rx_resync = 1'b0;
    check("resync_phase", rx_phase, 0);
    wait_q(0, nr + 1, "resync_rx");
    check("resync_first_tick", at(0, nr) - r, 10);
    wait_q(2, nm + 1, "resync_mid");
    check("resync_mid_time", at(2, nm) - r, 80);

    // rx_resync on the edge that would end a period cancels that strobe
    b = 0;
    while (cyc < r + 89 && b < 1000) begin step(); b++; end
    check("resync2_align", cyc, r + 89);
    nr = rx_q.size();
    rx_resync = 1'b1;
    r2 = cyc + 1;
    step();
    rx_resync = 1'b0;
    check("resync2_cancel_tick", rx_tick, 0);
    check("resync2_phase", rx_phase, 0);
    wait_q(0, nr + 1, "resync2_rx");
    check("resync2_next_tick", at(0, nr) - r2, 10);
    wait_q(1, nt + 1, "resync_tx");
    check("resync_tx_cadence", at(1, nt) - at(1, nt - 1), 160);

    // en dropped mid-period
    repeat (3) step();
    en = 1'b0;
    step();
    check("en_low_rx_tick", rx_tick, 0);
    check("en_low_tx_tick", tx_tick, 0);
    check("en_low_rx_phase", rx_phase, 0);
    check("en_low_pending", div_pending, 0);
    nr = rx_q.size();
    nt = tx_q.size();
    repeat (30) step();
    check("en_low_no_rx", rx_q.size() - nr, 0);
    check("en_low_no_tx", tx_q.size() - nt, 0);

    // Table: write while held, then start from cleared state
    for (int i = 0; i < 5; i++) begin
      div_int = vecs[i].di;
      div_frac = vecs[i].df;
      div_wr = 1'b1;
      step();
      div_wr = 1'b0;
      check($sformatf("vec%0d_pending_on", i), div_pending, 1);
      step();
      check($sformatf("vec%0d_pending_off", i), div_pending, 0);
      nr = rx_q.size();
      nt = tx_q.size();
      en = 1'b1;
      s = cyc + 1;
      wait_q(0, nr + 2, $sformatf("vec%0d_rx", i));
      wait_q(1, nt + 1, $sformatf("vec%0d_tx", i));
      check($sformatf("vec%0d_p0", i), at(0, nr) - s, vecs[i].p0);
      check($sformatf("vec%0d_p1", i), at(0, nr + 1) - at(0, nr), vecs[i].p1);
      check($sformatf("vec%0d_tx", i), at(1, nt) - s, vecs[i].ptx);
      en = 1'b0;
      step();
      step();
    end

    // Asynchronous reset during an rx_tick cycle
    en = 1'b1;
    nr = rx_q.size();
    wait_q(0, nr + 1, "prereset_rx");
    check("prereset_rx_tick", rx_tick, 1);
    rst_n = 1'b0;
    #1;
    check("async_rx_tick", rx_tick, 0);
    check("async_rx_phase", rx_phase, 0);
    check("async_rx_mid", rx_mid, 0);
    check("async_tx_tick", tx_tick, 0);
    check("async_pending", div_pending, 0);
    repeat (3) step();
    rx_q.delete();
    tx_q.delete();
    mid_q.delete();
    ph_q.delete();
    rst_n = 1'b1;
    s = cyc + 1;
    wait_q(0, 2, "postreset_rx");
    check("postreset_p0", at(0, 0) - s, 651);
    check("postreset_p1", at(0, 1) - at(0, 0), 651);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
